// File: rtl/tas_pkg.sv
// Shared types and constants for the temperature-averaging serial link.
package tas_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } tx_state_t;

    localparam logic [7:0] HDR_A         = 8'hA5;
    localparam logic [7:0] HDR_B         = 8'hC3;
    localparam int         BYTES_PER_PKT = 5;
    localparam int         TEMPS_PER_PKT = 4;

    // A packet is only meaningful to the receiver with one of the two known headers.
    function automatic logic hdr_is_valid(input logic [7:0] hdr);
        return (hdr == HDR_A) || (hdr == HDR_B);
    endfunction

endpackage

// File: rtl/tas_avg_calc.sv
// Combinational golden-value calculator: average of four temperature bytes
// and header validity. The parent registers both on start acceptance.
module tas_avg_calc
    import tas_pkg::*;
(
    input  logic [7:0]  header,
    input  logic [31:0] temp_data,
    output logic        hdr_valid,
    output logic [7:0]  avg
);

    logic [9:0] sum_s;

    // Ten bits hold 4*255 without overflow; dropping the two LSBs divides by four.
    always_comb begin
        sum_s     = {2'b00, temp_data[7:0]}   + {2'b00, temp_data[15:8]}
                  + {2'b00, temp_data[23:16]} + {2'b00, temp_data[31:24]};
        avg       = sum_s[9:2];
        hdr_valid = hdr_is_valid(header);
    end

endmodule

// File: rtl/tas_serial_tx.sv
// Serial packet transmitter: five bytes (header then four temperatures),
// LSB first, framed by data_ena with idle gaps between bytes. Also reports
// the average the receiver is expected to compute.
module tas_serial_tx
    import tas_pkg::*;
#(
    parameter int BIT_CYCLES = 1,
    parameter int GAP_CYCLES = 4,
    parameter int NUM_BYTES  = 5
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  header,
    input  logic [31:0] temp_data,
    output logic        serial_data,
    output logic        data_ena,
    output logic        busy,
    output logic        done,
    output logic        hdr_valid,
    output logic [7:0]  avg_expected
);

    localparam logic [7:0] BIT_RELOAD = 8'(BIT_CYCLES - 1);
    localparam logic [7:0] GAP_RELOAD = 8'(GAP_CYCLES - 1);
    localparam logic [2:0] LAST_BYTE  = 3'(NUM_BYTES - 1);

    tx_state_t   state_q,  state_d;
    logic [39:0] sr_q,     sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  cyc_cnt_q, cyc_cnt_d;
    logic        serial_q, serial_d;
    logic        ena_q,    ena_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;
    logic        hv_q,     hv_d;
    logic [7:0]  avg_q,    avg_d;

    logic        calc_hv_s;
    logic [7:0]  calc_avg_s;

    tas_avg_calc u_avg_calc (
        .header    (header),
        .temp_data (temp_data),
        .hdr_valid (calc_hv_s),
        .avg       (calc_avg_s)
    );

    // Next-state logic; cyc_cnt is a down-counter reloaded on every state change.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        serial_d   = serial_q;
        ena_d      = ena_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hv_d       = hv_q;
        avg_d      = avg_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d       = {temp_data, header};
                    serial_d   = header[0];
                    ena_d      = 1'b1;
                    busy_d     = 1'b1;
                    hv_d       = calc_hv_s;
                    avg_d      = calc_avg_s;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 3'd0;
                    cyc_cnt_d  = BIT_RELOAD;
                    state_d    = SHIFT;
                end else begin
                    serial_d = 1'b0;
                    ena_d    = 1'b0;
                end
            end
            SHIFT: begin
                if (cyc_cnt_q != 8'd0) begin
                    cyc_cnt_d = cyc_cnt_q - 8'd1;
                end else begin
                    // Shift on every bit, including the last, so the next byte's bit0 lands in sr[0].
                    sr_d      = {1'b0, sr_q[39:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        ena_d    = 1'b0;
                        serial_d = 1'b0;
                        if (byte_cnt_q == LAST_BYTE) begin
                            cyc_cnt_d = 8'd0;
                            state_d   = DONE;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 3'd1;
                            cyc_cnt_d  = GAP_RELOAD;
                            state_d    = GAP;
                        end
                    end else begin
                        serial_d  = sr_q[1];
                        cyc_cnt_d = BIT_RELOAD;
                    end
                end
            end
            GAP: begin
                if (cyc_cnt_q != 8'd0) begin
                    cyc_cnt_d = cyc_cnt_q - 8'd1;
                end else begin
                    serial_d  = sr_q[0];
                    ena_d     = 1'b1;
                    cyc_cnt_d = BIT_RELOAD;
                    state_d   = SHIFT;
                end
            end
            DONE: begin
                // start is not looked at here, so a request in this cycle is dropped.
                done_d     = 1'b1;
                busy_d     = 1'b0;
                sr_d       = 40'd0;
                bit_cnt_d  = 3'd0;
                byte_cnt_d = 3'd0;
                cyc_cnt_d  = 8'd0;
                state_d    = IDLE;
            end
            default: begin
                serial_d   = 1'b0;
                ena_d      = 1'b0;
                busy_d     = 1'b0;
                sr_d       = 40'd0;
                bit_cnt_d  = 3'd0;
                byte_cnt_d = 3'd0;
                cyc_cnt_d  = 8'd0;
                state_d    = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset clears everything immediately.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sr_q       <= 40'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 3'd0;
            cyc_cnt_q  <= 8'd0;
            serial_q   <= 1'b0;
            ena_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hv_q       <= 1'b0;
            avg_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            serial_q   <= serial_d;
            ena_q      <= ena_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hv_q       <= hv_d;
            avg_q      <= avg_d;
        end
    end

    assign serial_data  = serial_q;
    assign data_ena     = ena_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign hdr_valid    = hv_q;
    assign avg_expected = avg_q;

endmodule

// File: doc/tas_serial_tx.md
Name: tas_serial_tx

Overview:
- Serial packet transmitter for the temperature averaging path. It is the sending end of the serial_data/data_ena link that tas consumes.
- Takes one parallel packet (header byte plus four temperature bytes) and serializes it LSB-first as five 8-bit bursts framed by data_ena, with idle gaps between bytes.
- Also outputs the average the receiver must compute, giving benches and system-level checks a golden value.

Parameters:
- BIT_CYCLES, 1, clk_50 cycles each serial bit is held (1..15)
- GAP_CYCLES, 4, idle cycles with data_ena low between consecutive bytes (2..255)
- NUM_BYTES, 5, bytes per packet including header (fixed at 5; other values unsupported)

Ports:
- clk_50  input  1  50 MHz clock, the only clock
- reset_n  input  1  asynchronous reset, active low
- start  input  1  one-cycle request; sampled only in IDLE
- header  input  8  header byte, sent first (8'hA5 or 8'hC3 for a valid packet)
- temp_data  input  32  four temperature bytes; [7:0] sent second, [31:24] sent last
- serial_data  output  1  serial bit, LSB of each byte first
- data_ena  output  1  high for the full 8 bits of each byte
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse after the last bit of the final byte
- hdr_valid  output  1  latched header is 8'hA5 or 8'hC3
- avg_expected  output  8  (sum of the 4 latched temperature bytes) >> 2

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-packet): all outputs 0, state IDLE, shift register and counters cleared.
- Every output is driven from a register. No combinational path from any input to any output.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 at clock edge k latches {temp_data, header} into a 40-bit shift register.
  - Same edge: compute hdr_valid and avg_expected (10-bit sum, upper 8 bits of the sum taken as the result).
  - Move to SHIFT. At edge k, serial_data=header[0], data_ena=1 and busy=1 all take effect.
- SHIFT:
  - Each bit is held for BIT_CYCLES cycles.
  - After 8 bits, data_ena drops on the next edge.
  - If more bytes remain, go to GAP; after the fifth byte, go to DONE.
- GAP:
  - data_ena=0 and serial_data=0 for exactly GAP_CYCLES cycles.
  - Then return to SHIFT with the next byte's bit0.
- DONE:
  - done=1 for exactly one cycle, busy goes to 0 on the same edge, then IDLE.
  - A start in that same cycle is ignored.
- Frame length: start edge to done pulse is 40*BIT_CYCLES + 4*GAP_CYCLES cycles, plus 1 for DONE.
- start asserted while busy is ignored. Latched data does not change mid-packet.
- hdr_valid and avg_expected hold their values until the next accepted start. They are not cleared by done.
- An invalid header is still transmitted unchanged (the receiver must discard it). hdr_valid=0 flags this.
- Sum overflow is impossible: 4*255=1020 fits in 10 bits.
- Counters:
  - bit_cnt is 3 bits; wraparound from 7 marks the byte end.
  - byte_cnt is 3 bits and counts 0..4.
  - cyc_cnt is 8 bits, shared between bit hold and gap timing, and reloads on every state change.

Decomposition:
- Shared package tas_pkg:
  - tx_state_t enum {IDLE, SHIFT, GAP, DONE}
  - constants HDR_A = 8'hA5, HDR_B = 8'hC3, BYTES_PER_PKT = 5, TEMPS_PER_PKT = 4
- One natural sub-module: tas_avg_calc (combinational 4-byte sum and >>2 plus header compare), registered in the parent on start acceptance.
- The serializer FSM stays in tas_serial_tx.

Test Plan:
- Reset, then start with header=A5 and temp_data=32'h20_1E_1C_1A:
  - Byte stream on data_ena windows is A5, 1A, 1C, 1E, 20, each LSB first.
  - avg_expected=8'h1D, hdr_valid=1.
  - done arrives after 57 cycles (BIT=1, GAP=4).
- Header=8'h3C, temp_data=32'hFF_FF_FF_FF:
  - hdr_valid=0, avg_expected=8'hFF.
  - The 3C byte is still transmitted.
- start pulsed again in the 20th cycle of a packet: ignored; stream and latched data unchanged; exactly one done.
- reset_n asserted low mid-packet during the third byte: serial_data, data_ena, busy, done, hdr_valid and avg_expected are 0 asynchronously. A new start after release sends a clean full packet.
- BIT_CYCLES=3, GAP_CYCLES=2: every bit is held 3 cycles and gaps are 2 cycles; done arrives at cycle 129.
- Loopback into tas with four C3 packets of temps 10, 20, 30, 40:
  - tas writes 8'h19 (25) to ram_addr 11'h7FF.
  - This matches avg_expected.
